// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decryption engine.
// Optional build macro: ARC4_DROP256_EN (see arc4_decrypt.sv).
package arc4_pkg;

  localparam int KEY_LEN     = 3;
  localparam int SBOX_SIZE   = 256;
  localparam int CYCLES_BASE = 1026;

  // Controller states: set-up, key schedule, length copy, keystream loop.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KA,
    ST_KB,
    ST_KC,
    ST_LEN_RD,
    ST_LEN_WR,
    ST_PI,
    ST_PS1,
    ST_PS2,
    ST_PO
  } state_e;

  // Key byte 0 is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = key[23:16];
      2'd1:    b = key[15:8];
      default: b = key[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/arc4_sbox.sv
// 256-byte RC4 state box: one combinational read port, one combinational
// pad port returning S[S[a]+S[b]], one synchronous write port.
module arc4_sbox
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  input  logic [7:0] pad_a_i,
  input  logic [7:0] pad_b_i,
  output logic [7:0] pad_o,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i
);

  // Contents are undefined after reset; the controller always rebuilds them.
  logic [7:0] mem_q [SBOX_SIZE];
  logic [7:0] pad_idx;

  // Single write per cycle from the controller.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read ports; the index sum wraps modulo 256 by width.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
    pad_idx   = mem_q[pad_a_i] + mem_q[pad_b_i];
    pad_o     = mem_q[pad_idx];
  end

endmodule

// File: rtl/arc4_decrypt.sv
// ARC4 decryption engine with a 24-bit key. Reads a length-prefixed
// ciphertext from an external RAM (1-cycle registered read) and writes the
// length-prefixed plaintext to a second external RAM.
// Optional build macro: ARC4_DROP256_EN discards the first 256 keystream
// bytes before decrypting.
module arc4_decrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,      // active-high asynchronous reset
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren
);

  // Handshake: a start is accepted at any rising edge where en and rdy are
  // both 1; rdy drops on that same edge and en is ignored until rdy returns.

  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  tmp_q, tmp_d;
  logic [7:0]  len_q, len_d;
  logic [23:0] key_q, key_d;
  logic [1:0]  kidx_q, kidx_d;
`ifdef ARC4_DROP256_EN
  logic        drop_q, drop_d;
`endif

  logic [7:0] sb_rd_addr, sb_rd_data, sb_pad;
  logic       sb_we;
  logic [7:0] sb_wa, sb_wd;

  logic unused_pt_rddata;
  assign unused_pt_rddata = ^pt_rddata;

  arc4_sbox u_sbox (
    .clk       (clk),
    .rd_addr_i (sb_rd_addr),
    .rd_data_o (sb_rd_data),
    .pad_a_i   (i_q),
    .pad_b_i   (j_q),
    .pad_o     (sb_pad),
    .wr_en_i   (sb_we),
    .wr_addr_i (sb_wa),
    .wr_data_i (sb_wd)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      tmp_q   <= '0;
      len_q   <= '0;
      key_q   <= '0;
      kidx_q  <= '0;
`ifdef ARC4_DROP256_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tmp_q   <= tmp_d;
      len_q   <= len_d;
      key_q   <= key_d;
      kidx_q  <= kidx_d;
`ifdef ARC4_DROP256_EN
      drop_q  <= drop_d;
`endif
    end
  end

  // Next-state logic and S-box port control.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    tmp_d      = tmp_q;
    len_d      = len_q;
    key_d      = key_q;
    kidx_d     = kidx_q;
`ifdef ARC4_DROP256_EN
    drop_d     = drop_q;
`endif
    sb_rd_addr = i_q;
    sb_we      = 1'b0;
    sb_wa      = i_q;
    sb_wd      = sb_rd_data;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          key_d   = key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kidx_d  = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        sb_we = 1'b1;
        sb_wa = i_q;
        sb_wd = i_q;
        i_d   = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = ST_KA;
      end
      ST_KA: begin
        sb_rd_addr = i_q;
        j_d        = j_q + sb_rd_data + key_byte(key_q, kidx_q);
        tmp_d      = sb_rd_data;
        state_d    = ST_KB;
      end
      ST_KB: begin
        sb_rd_addr = j_q;
        sb_we      = 1'b1;
        sb_wa      = i_q;
        sb_wd      = sb_rd_data;
        state_d    = ST_KC;
      end
      ST_KC: begin
        sb_we   = 1'b1;
        sb_wa   = j_q;
        sb_wd   = tmp_q;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == 2'(KEY_LEN - 1)) ? 2'd0 : kidx_q + 2'd1;
        state_d = (i_q == 8'hFF) ? ST_LEN_RD : ST_KA;
      end
      ST_LEN_RD: begin
        // ct_addr follows k_q, which is still 0 here.
        state_d = ST_LEN_WR;
      end
      ST_LEN_WR: begin
        len_d = ct_rddata;
        i_d   = '0;
        j_d   = '0;
`ifdef ARC4_DROP256_EN
        drop_d  = 1'b1;
        state_d = ST_PI;
`else
        if (ct_rddata == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          k_d     = 8'd1;
          state_d = ST_PI;
        end
`endif
      end
      ST_PI: begin
        sb_rd_addr = i_q + 8'd1;
        i_d        = i_q + 8'd1;
        j_d        = j_q + sb_rd_data;
        tmp_d      = sb_rd_data;
        state_d    = ST_PS1;
      end
      ST_PS1: begin
        sb_rd_addr = j_q;
        sb_we      = 1'b1;
        sb_wa      = i_q;
        sb_wd      = sb_rd_data;
        state_d    = ST_PS2;
      end
      ST_PS2: begin
        sb_we   = 1'b1;
        sb_wa   = j_q;
        sb_wd   = tmp_q;
        state_d = ST_PO;
`ifdef ARC4_DROP256_EN
        // i starts at 0 and is bumped once per iteration, so it is back at
        // 0 exactly after the 256th discard iteration.
        if (drop_q) begin
          if (i_q == 8'd0) begin
            drop_d = 1'b0;
            if (len_q == 8'd0) begin
              state_d = ST_IDLE;
            end else begin
              k_d     = 8'd1;
              state_d = ST_PI;
            end
          end else begin
            state_d = ST_PI;
          end
        end
`endif
      end
      ST_PO: begin
        if (k_q == len_q) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = ST_PI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; k is held from PI through PO.
  always_comb begin
    rdy       = (state_q == ST_IDLE);
    ct_addr   = k_q;
    pt_addr   = k_q;
    pt_wren   = (state_q == ST_LEN_WR) || (state_q == ST_PO);
    pt_wrdata = '0;
    if (state_q == ST_LEN_WR) pt_wrdata = ct_rddata;
    else if (state_q == ST_PO) pt_wrdata = ct_rddata ^ sb_pad;
  end

endmodule

// File: tb/tb_arc4_decrypt.sv
// Directed testbench for arc4_decrypt with an RC4 reference model.
// Build with +define+ARC4_DROP256_EN to check the drop-256 variant.
module tb_arc4_decrypt;

`ifdef ARC4_DROP256_EN
  localparam bit DROP  = 1'b1;
  localparam int EXTRA = 768;
`else
  localparam bit DROP  = 1'b0;
  localparam int EXTRA = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_rddata;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;

  logic [7:0]  ct_mem [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  exp_pt [256];
  logic [15:0] exp_q[$];   // {addr, data} of each expected write, in order

  logic [7:0]  key_ct [10];
  logic [7:0]  key_pt [10];

  int n_checks;
  int n_fail;

  arc4_decrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAMs with 1-cycle registered read
  always @(posedge clk) begin
    ct_rddata <= ct_mem[ct_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every write must match the next expected write
  always @(negedge clk) begin
    if (!rst_n && pt_wren) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'd0, pt_addr, 8'd0, pt_wrdata}, 32'hFFFF_FFFF);
      end else begin
        chk("write_addr_data", {pt_addr, pt_wrdata}, exp_q.pop_front());
      end
    end
  end

  // Reference RC4 (optionally drop-256) over the current ct_mem contents
  task automatic build_model(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] t;
    logic [7:0] kb;
    int j, i, L, drops;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = 8'((k >> (8 * (2 - (n % 3)))) & 24'hFF);
      j = (j + int'(s[n]) + int'(kb)) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    L = int'(ct_mem[0]);
    exp_pt[0] = ct_mem[0];
    exp_q.push_back({8'd0, ct_mem[0]});
    drops = DROP ? 256 : 0;
    i = 0;
    j = 0;
    for (int n = 1; n <= drops + L; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (n > drops) begin
        exp_pt[n - drops] = ct_mem[n - drops] ^ s[(int'(s[i]) + int'(s[j])) % 256];
        exp_q.push_back({8'(n - drops), exp_pt[n - drops]});
      end
    end
  endtask

  // Start a run (called at a negedge with rdy=1) and wait for completion
  task automatic do_run(input logic [23:0] k, input int hold, input bit chg_key, output int busy);
    int  cyc;
    bit  done;
    build_model(k);
    key  = k;
    en   = 1'b1;
    busy = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) en = 1'b0;
      if (chg_key && cyc == 30) key = 24'($urandom);
      if (rdy) done = 1'b1;
      else busy++;
    end
    en = 1'b0;
    if (!done) chk("run_timeout", 32'(cyc), 32'(busy));
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_key_vec();
    for (int n = 0; n < 10; n++) ct_mem[n] = key_ct[n];
  endtask

  task automatic check_pt(input string tag, input int L);
    for (int n = 0; n <= L; n++) chk({tag, "_pt_mem"}, {24'd0, pt_mem[n]}, {24'd0, exp_pt[n]});
  endtask

  // Hand-computed literal "Plaintext" pins the model (plain RC4 only)
  task automatic check_literal(input string tag);
    chk({tag, "_lit_len"}, {24'd0, pt_mem[0]}, 32'h09);
    if (!DROP) begin
      for (int n = 1; n < 10; n++) chk({tag, "_lit_pt"}, {24'd0, pt_mem[n]}, {24'd0, key_pt[n]});
    end
  endtask

  initial begin
    int busy;
    n_checks = 0;
    n_fail   = 0;
    key_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    key_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int n = 0; n < 256; n++) ct_mem[n] = 8'(n * 7 + 3);
    en    = 1'b0;
    key   = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'd0, rdy}, 32'd1);
    chk("reset_ct_addr", {24'd0, ct_addr}, 32'd0);
    chk("reset_pt_addr", {24'd0, pt_addr}, 32'd0);
    chk("reset_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
    chk("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // "Key" test vector
    load_key_vec();
    do_run(24'h4B6579, 1, 1'b0, busy);
    chk("key_busy", 32'(busy), 32'(1062 + EXTRA));
    check_pt("key", 9);
    check_literal("key");

    // L = 0: only the length byte is written
    ct_mem[0] = 8'h00;
    do_run(24'($urandom), 1, 1'b0, busy);
    chk("len0_busy", 32'(busy), 32'(1026 + EXTRA));
    chk("len0_pt0", {24'd0, pt_mem[0]}, 32'd0);

    // en held for 20 cycles, key changed mid-run
    ct_mem[0] = 8'd5;
    ct_mem[1] = 8'h11; ct_mem[2] = 8'h22; ct_mem[3] = 8'h33;
    ct_mem[4] = 8'h44; ct_mem[5] = 8'h55;
    do_run(24'h010203, 20, 1'b1, busy);
    chk("hold_busy", 32'(busy), 32'(1046 + EXTRA));
    check_pt("hold", 5);
    repeat (10) @(negedge clk);
    chk("hold_single_run", {31'd0, rdy}, 32'd1);

    // Reset in the middle of the key schedule
    load_key_vec();
    key = 24'h123456;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (499) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rdy", {31'd0, rdy}, 32'd1);
    chk("midrst_pt_wren", {31'd0, pt_wren}, 32'd0);
    chk("midrst_ct_addr", {24'd0, ct_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    do_run(24'h4B6579, 1, 1'b0, busy);
    chk("after_rst_busy", 32'(busy), 32'(1062 + EXTRA));
    check_literal("after_rst");
    check_pt("after_rst", 9);

    // Back-to-back: restart in the first rdy cycle
    do_run(24'h4B6579, 1, 1'b0, busy);
    chk("b2b_busy", 32'(busy), 32'(1062 + EXTRA));
    check_literal("b2b");
    check_pt("b2b", 9);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_decrypt.md
# arc4_decrypt

RC4 (ARC4) stream-cipher decryption engine with a 24-bit key. On a start handshake it builds the 256-byte state box and runs the key schedule. It then reads a length-prefixed ciphertext from an external ciphertext memory and writes the length-prefixed plaintext into an external plaintext memory. Both memories are 256x8 single-port RAMs with a 1-cycle registered read, owned by the enclosing top level.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-high (asserted = 1).
- `en` in 1: start request; honoured only while `rdy`=1.
- `rdy` out 1: idle/ready.
- `key` in 24: key bytes `key[23:16]`, `key[15:8]`, `key[7:0]` (index 0,1,2).
- `ct_addr` out 8: ciphertext memory address.
- `ct_rddata` in 8: ciphertext memory q; valid 1 cycle after `ct_addr`.
- `pt_addr` out 8: plaintext memory address.
- `pt_rddata` in 8: plaintext memory q; unused, tolerated.
- `pt_wrdata` out 8: plaintext write data.
- `pt_wren` out 1: plaintext write enable.

## Operation
- Message format:
  - `ct[0]` = L (0..255); `ct[1..L]` = ciphertext.
  - Output `pt[0]` = L; `pt[k]` = `ct[k]` XOR keystream byte k.
- Start: `en`&`rdy` at a rising edge. `key` is latched; later `key` changes are ignored. `i`, `j` and `k` are cleared.
- States and work per state:
  - IDLE: `rdy`=1.
  - INIT: 256 cycles; S[n]=n.
  - KSA: for i=0..255, 3 cycles each:
    - KA: j=j+S[i]+key[i mod 3]; tmp=S[i].
    - KB: S[i]=S[j].
    - KC: S[j]=tmp.
  - LEN_RD: `ct_addr`=0.
  - LEN_WR: latch L; write `pt[0]`=L; i=j=0.
  - PRGA, for k=1..L, 4 cycles each:
    - PI: i=i+1; j=j+S[i]; tmp=S[i]; `ct_addr`=k.
    - PS1: S[i]=S[j].
    - PS2: S[j]=tmp.
    - PO: pad=S[S[i]+S[j]]; `pt_addr`=k; `pt_wrdata`=`ct_rddata`^pad; `pt_wren`=1.
  - After the last PO (or LEN_WR if L=0) → IDLE.
- Arithmetic: all i, j and index sums are 8-bit modulo 256; the key index is a 2-bit counter wrapping 2→0.
- `en` while busy: ignored; no queuing.

## Timing
- Reset values: `rdy`=1, `ct_addr`=0, `pt_addr`=0, `pt_wrdata`=0, `pt_wren`=0, state IDLE, i=j=k=0. S contents are don't-care.
- `rdy` falls on the edge that samples the start. It stays low for exactly 1026+4L cycles and is high in the cycle after the last write.
- `pt_wren` is a 1-cycle pulse, asserted only in LEN_WR and PO.
- `ct_addr` is held from PI through PO, so `ct_rddata` is stable in PO.
- Reset mid-operation: immediate return to reset values. The partially written pt memory is left as-is.
- A new start may be accepted in the first `rdy`=1 cycle.

## Configuration
- `ARC4_DROP256_EN`:
  - Defined: after LEN_WR, 256 discard iterations (PI, PS1, PS2; no `ct_addr` change and no write) run before k=1. Busy time is 1794+4L.
  - Undefined: plain RC4 as above.

## Structure
- Package `arc4_pkg`:
  - state enum.
  - `KEY_LEN`=3.
  - `SBOX_SIZE`=256.
  - `CYCLES_BASE`=1026.
- Sub-module `arc4_sbox`:
  - 256x8 register array.
  - Two combinational read ports: one indexed by address, one returning S[S[a]+S[b]] for the pad.
  - One synchronous write port.
- Controller FSM, counters, key latch and XOR live in `arc4_decrypt`.

## Test plan
- Key "Key": key=24'h4B6579; ct = 09 BB F3 16 E8 D9 40 AF 0A D3 → pt = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); `rdy` low exactly 1062 cycles.
- L=0: ct[0]=00, any key → single write `pt[0]`=00; `rdy` low 1026 cycles; no other `pt_wren`.
- Handshake: hold `en`=1 for 20 cycles from start → exactly one run; `key` changed mid-run does not alter output.
- Reset mid-KSA: assert `rst_n` at cycle 500 → `rdy`=1 and `pt_wren`=0 immediately. A subsequent full run with the "Key" vector is correct.
- Back-to-back: restart in the first `rdy` cycle with the same vector → identical pt; no stale j carried over.
- With `ARC4_DROP256_EN`: same "Key" vector → `rdy` low 1830 cycles; pt[0]=09 and pt[1..9] match the reference RC4-drop256 model.
